sync_debounce: RTL and testbench

SYNC_DEBOUNCE -- requirements
Module: sync_debounce

---
 rtl/sync_debounce_pkg.sv | 15 +
 rtl/debounce_bit.sv | 61 ++++++
 rtl/sync_debounce.sv | 56 +++++
 tb/tb_sync_debounce.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_debounce_pkg.sv
// Shared constants for the synchronizer / debounce family.
// Holds the default WIDTH and COUNT values and the counter-width helper,
// so that every block sizing a debounce counter derives it the same way.
package sync_debounce_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_COUNT = 16;

    // Counter width for a debounce of 'count' samples: max(1, $clog2(count)).
    // A COUNT of 1 or 2 still needs a one-bit counter.
    function automatic int cnt_width(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debouncer: state bit, qualifying-sample counter and edge pulses.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   sample_en   - sample qualifier; nothing moves while low
//   in          - synchronized level input
//   out         - debounced level (registered)
//   rise, fall  - one-cycle pulses in the cycle out changes (registered)
//   update      - combinational "out changes on this edge"; feeds the
//                 changed register in the top, never a module output there
module debounce_bit
    import sync_debounce_pkg::*;
#(
    parameter int   COUNT     = DEFAULT_COUNT,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic update
);

    localparam int            CW   = cnt_width(COUNT);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    logic [CW-1:0] cnt;
    logic          differ;
    logic          at_last;

    assign differ  = (in != out);
    assign at_last = (cnt == LAST);
    assign update  = sample_en & differ & at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out  <= RESET_VAL;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= update & in;
            fall <= update & ~in;
            if (sample_en) begin
                // A matching sample discards any partial count; reaching the
                // last count accepts the new level and restarts from zero.
                if (!differ || at_last) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                if (update) begin
                    out <= in;
                end
            end
        end
    end

endmodule

// File: rtl/sync_debounce.sv
// Multi-bit debouncer for already-synchronized level inputs.
// Each bit is an independent debounce_bit; the top only adds the registered
// 'changed' flag (OR of all rise/fall pulses, aligned with them).
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   sample_en   - sample qualifier (prescaler tick), tie high for every cycle
//   in          - WIDTH synchronized inputs
//   out         - WIDTH debounced levels
//   rise, fall  - WIDTH one-cycle edge pulses
//   changed     - any rise/fall pulse this cycle
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               COUNT     = DEFAULT_COUNT,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    logic [WIDTH-1:0] update;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .COUNT     (COUNT),
            .RESET_VAL (RESET_VAL[i])
        ) u_bit (
            .clk       (clk),
            .rst_n     (rst_n),
            .sample_en (sample_en),
            .in        (in[i]),
            .out       (out[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .update    (update[i])
        );
    end

    // Registered from the per-bit update strobes so it lands in the same
    // cycle as the rise/fall pulses without a combinational path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed <= 1'b0;
        end else begin
            changed <= |update;
        end
    end

endmodule

// File: tb/tb_sync_debounce.sv
module tb_sync_debounce;

    localparam int W   = 8;
    localparam int CNT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sample_en = 1'b1;
    logic [W-1:0] in4 = '0;
    logic [W-1:0] in1 = '0;

    logic [W-1:0] out4, rise4, fall4;
    logic         chg4;
    logic [W-1:0] out1, rise1, fall1;
    logic         chg1;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sync_debounce #(.WIDTH(W), .COUNT(CNT), .RESET_VAL(8'h00)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .in        (in4),
        .out       (out4),
        .rise      (rise4),
        .fall      (fall4),
        .changed   (chg4)
    );

    sync_debounce #(.WIDTH(W), .COUNT(1), .RESET_VAL(8'h00)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (1'b1),
        .in        (in1),
        .out       (out1),
        .rise      (rise1),
        .fall      (fall1),
        .changed   (chg1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model. COUNT=4 instance: keep the last CNT enabled samples
    // per bit; the level is accepted when a full window disagrees with the
    // current debounced level. COUNT=1 instance: out is in one cycle late.
    bit           hist [W][$];
    logic [W-1:0] m_out = '0, m_rise = '0, m_fall = '0;
    logic         m_chg = 1'b0;
    logic [W-1:0] e1_out = '0, e1_rise = '0, e1_fall = '0;
    logic         e1_chg = 1'b0;

    initial begin
        logic [W-1:0] prev;
        bit           all_diff;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_out = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
                for (int i = 0; i < W; i++) hist[i].delete();
                e1_out = '0; e1_rise = '0; e1_fall = '0; e1_chg = 1'b0;
            end else begin
                m_rise = '0;
                m_fall = '0;
                if (sample_en) begin
                    for (int i = 0; i < W; i++) begin
                        hist[i].push_back(in4[i]);
                        if (hist[i].size() > CNT) void'(hist[i].pop_front());
                        all_diff = (hist[i].size() == CNT);
                        for (int j = 0; j < hist[i].size(); j++)
                            if (hist[i][j] == m_out[i]) all_diff = 1'b0;
                        if (all_diff) begin
                            m_out[i]  = ~m_out[i];
                            m_rise[i] = m_out[i];
                            m_fall[i] = ~m_out[i];
                        end
                    end
                end
                m_chg   = |(m_rise | m_fall);
                prev    = e1_out;
                e1_out  = in1;
                e1_rise = ~prev & e1_out;
                e1_fall = prev & ~e1_out;
                e1_chg  = |(e1_rise | e1_fall);
            end
        end
    end

    // Per-cycle comparison against the model, 1 time unit after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("out4",  {24'h0, out4},  {24'h0, m_out});
            chk("rise4", {24'h0, rise4}, {24'h0, m_rise});
            chk("fall4", {24'h0, fall4}, {24'h0, m_fall});
            chk("chg4",  {31'h0, chg4},  {31'h0, m_chg});
            chk("out1",  {24'h0, out1},  {24'h0, e1_out});
            chk("rise1", {24'h0, rise1}, {24'h0, e1_rise});
            chk("fall1", {24'h0, fall1}, {24'h0, e1_fall});
            chk("chg1",  {31'h0, chg1},  {31'h0, e1_chg});
        end
    end

    logic [W-1:0] last_in1;

    task automatic tick();
        @(negedge clk);
        last_in1 = in1;
        in1 = W'($urandom);
    endtask

    initial begin
        int en_cnt;
        logic [W-1:0] mask;

        repeat (2) tick();
        chk("reset_out",  {24'h0, out4}, 32'h00);
        chk("reset_rise", {24'h0, rise4 | fall4}, 32'h00);
        chk("reset_chg",  {31'h0, chg4}, 32'h0);

        // Single bit rises after the 4th sampling edge
        rst_n = 1'b1;
        in4 = 8'h01;
        repeat (3) tick();
        chk("lat_before", {24'h0, out4}, 32'h00);
        tick();
        chk("lat_out",  {24'h0, out4},  32'h01);
        chk("lat_rise", {24'h0, rise4}, 32'h01);
        chk("lat_fall", {24'h0, fall4}, 32'h00);
        chk("lat_chg",  {31'h0, chg4},  32'h1);
        chk("cnt1_follow", {24'h0, out1}, {24'h0, last_in1});
        tick();
        chk("lat_pulse_end", {24'h0, rise4}, 32'h00);

        // Three-sample glitch is discarded and the count restarts
        in4 = 8'h03;
        repeat (3) tick();
        in4 = 8'h01;
        repeat (2) tick();
        chk("glitch_out", {24'h0, out4}, 32'h01);
        in4 = 8'h03;
        repeat (3) tick();
        chk("glitch_recount", {24'h0, out4}, 32'h01);
        tick();
        chk("glitch_accept", {24'h0, out4}, 32'h03);
        in4 = 8'h00;
        repeat (4) tick();
        chk("dual_fall_out", {24'h0, out4},  32'h00);
        chk("dual_fall",     {24'h0, fall4}, 32'h03);

        // Sampling only every 3rd cycle
        in4 = 8'hFF;
        en_cnt = 0;
        for (int c = 0; c < 40 && en_cnt < 4; c++) begin
            sample_en = (c % 3 == 2);
            tick();
            if (sample_en) en_cnt++;
            if (sample_en && en_cnt == 3) chk("slow_before", {24'h0, out4}, 32'h00);
            if (sample_en && en_cnt == 4) begin
                chk("slow_out",  {24'h0, out4},  32'hFF);
                chk("slow_rise", {24'h0, rise4}, 32'hFF);
            end
        end
        chk("slow_enables", en_cnt, 4);
        sample_en = 1'b0;
        tick();
        chk("slow_hold_rise", {24'h0, rise4}, 32'h00);

        // Upper nibble falls together
        sample_en = 1'b1;
        in4 = 8'h0F;
        repeat (4) tick();
        chk("nib_out",  {24'h0, out4},  32'h0F);
        chk("nib_fall", {24'h0, fall4}, 32'hF0);
        chk("nib_rise", {24'h0, rise4}, 32'h00);
        chk("nib_chg",  {31'h0, chg4},  32'h1);

        // Reset mid-count
        in4 = 8'hFF;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_async_out", {24'h0, out4}, 32'h00);
        chk("rst_async_pulse", {23'h0, rise4 | fall4, chg4}, 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rst_recount", {24'h0, out4}, 32'h00);
        tick();
        chk("rst_accept_out",  {24'h0, out4},  32'hFF);
        chk("rst_accept_rise", {24'h0, rise4}, 32'hFF);

        // Bit 0 toggling faster than COUNT samples never settles
        for (int k = 0; k < 10; k++) begin
            in4 = 8'hFE;
            repeat (3) tick();
            in4 = 8'hFF;
            tick();
        end
        chk("fast_toggle", {24'h0, out4}, 32'hFF);

        // Random traffic with sparse flips and a mid-run reset
        for (int c = 0; c < 400; c++) begin
            mask = '0;
            for (int b = 0; b < W; b++) mask[b] = ($urandom_range(0, 5) == 0);
            in4 = in4 ^ mask;
            sample_en = ($urandom_range(0, 3) != 0);
            rst_n = (c != 200);
            tick();
        end
        rst_n = 1'b1;
        repeat (2) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
